// File: rtl/register_table.sv
// register_table
//   Register file and issue stage for the fixed-point execution pipes.
//   Holds the NUM_REGS x REG_WIDTH register table, reads ra/rb operands for
//   each decoded instruction, tracks in-flight destination writes in a
//   per-register pending scoreboard, and stalls decode on RAW/WAW hazards.
//   One registered instruction (or a nop) is presented to the execution
//   unit every cycle; the unit's writeback port updates the table.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   dec_valid            decode presents an instruction
//   dec_op/format/imm    fields passed through to issue
//   dec_ra/rb_addr       source register addresses
//   dec_rt_addr          destination register address
//   dec_reg_write        instruction writes rt
//   dec_stall            combinational; instruction not accepted this cycle
//   op/format/imm/rt_addr/reg_write, ra/rb
//                        registered issue fields and operand values
//   rt_wb/rt_addr_wb/reg_write_wb
//                        writeback from the execution unit
module register_table #(
  parameter int NUM_REGS  = 128,
  parameter int REG_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [0:10]          dec_op,
  input  logic [2:0]           dec_format,
  input  logic [0:17]          dec_imm,
  input  logic [0:6]           dec_ra_addr,
  input  logic [0:6]           dec_rb_addr,
  input  logic [0:6]           dec_rt_addr,
  input  logic                 dec_reg_write,
  output logic                 dec_stall,
  output logic [0:10]          op,
  output logic [2:0]           format,
  output logic [0:17]          imm,
  output logic [0:6]           rt_addr,
  output logic                 reg_write,
  output logic [0:REG_WIDTH-1] ra,
  output logic [0:REG_WIDTH-1] rb,
  input  logic [0:REG_WIDTH-1] rt_wb,
  input  logic [0:6]           rt_addr_wb,
  input  logic                 reg_write_wb
);

  // Read views of the per-entry storage built below.
  logic [0:REG_WIDTH-1] regs [NUM_REGS];
  logic [0:NUM_REGS-1]  pending;

  logic accept;
  logic ra_hit_wb, rb_hit_wb, rt_hit_wb;
  logic ra_blocked, rb_blocked, rt_blocked;
  logic [0:REG_WIDTH-1] ra_next, rb_next;

  // A writeback to the same address in this cycle both clears the hazard
  // and supplies the operand, so decode never waits an extra cycle.
  assign ra_hit_wb = reg_write_wb && (rt_addr_wb == dec_ra_addr);
  assign rb_hit_wb = reg_write_wb && (rt_addr_wb == dec_rb_addr);
  assign rt_hit_wb = reg_write_wb && (rt_addr_wb == dec_rt_addr);

  assign ra_blocked = pending[dec_ra_addr] && !ra_hit_wb;
  assign rb_blocked = pending[dec_rb_addr] && !rb_hit_wb;
  // WAW: keeps at most one write per register in flight.
  assign rt_blocked = dec_reg_write && pending[dec_rt_addr] && !rt_hit_wb;

  assign dec_stall = dec_valid && (ra_blocked || rb_blocked || rt_blocked);
  assign accept    = dec_valid && !dec_stall;

  assign ra_next = ra_hit_wb ? rt_wb : regs[dec_ra_addr];
  assign rb_next = rb_hit_wb ? rt_wb : regs[dec_rb_addr];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      logic [0:REG_WIDTH-1] entry_reg;
      logic                 pend_reg;
      logic                 wb_hit;
      logic                 set_hit;

      assign wb_hit  = reg_write_wb && (rt_addr_wb == 7'(gi));
      assign set_hit = accept && dec_reg_write && (dec_rt_addr == 7'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entry_reg <= '0;
        end else if (wb_hit) begin
          entry_reg <= rt_wb;
        end
      end

      // Set takes priority: a new producer issuing in the same cycle the old
      // one writes back leaves the register pending.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pend_reg <= 1'b0;
        end else if (set_hit) begin
          pend_reg <= 1'b1;
        end else if (wb_hit) begin
          pend_reg <= 1'b0;
        end
      end

      assign regs[gi]    = entry_reg;
      assign pending[gi] = pend_reg;
    end
  endgenerate

  // Issue register: loads the accepted instruction, otherwise a nop.
  logic [0:10]          op_reg;
  logic [2:0]           format_reg;
  logic [0:17]          imm_reg;
  logic [0:6]           rt_addr_reg;
  logic                 reg_write_reg;
  logic [0:REG_WIDTH-1] ra_reg, rb_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg        <= '0;
      format_reg    <= '0;
      imm_reg       <= '0;
      rt_addr_reg   <= '0;
      reg_write_reg <= 1'b0;
      ra_reg        <= '0;
      rb_reg        <= '0;
    end else if (accept) begin
      op_reg        <= dec_op;
      format_reg    <= dec_format;
      imm_reg       <= dec_imm;
      rt_addr_reg   <= dec_rt_addr;
      reg_write_reg <= dec_reg_write;
      ra_reg        <= ra_next;
      rb_reg        <= rb_next;
    end else begin
      op_reg        <= '0;
      format_reg    <= '0;
      imm_reg       <= '0;
      rt_addr_reg   <= '0;
      reg_write_reg <= 1'b0;
      ra_reg        <= '0;
      rb_reg        <= '0;
    end
  end

  assign op        = op_reg;
  assign format    = format_reg;
  assign imm       = imm_reg;
  assign rt_addr   = rt_addr_reg;
  assign reg_write = reg_write_reg;
  assign ra        = ra_reg;
  assign rb        = rb_reg;

endmodule

// File: tb/tb_register_table.sv
module tb_register_table;

  logic         clk = 1'b0;
  logic         reset;
  logic         dec_valid;
  logic [0:10]  dec_op;
  logic [2:0]   dec_format;
  logic [0:17]  dec_imm;
  logic [0:6]   dec_ra_addr, dec_rb_addr, dec_rt_addr;
  logic         dec_reg_write;
  logic         dec_stall;
  logic [0:10]  op;
  logic [2:0]   format;
  logic [0:17]  imm;
  logic [0:6]   rt_addr;
  logic         reg_write;
  logic [0:127] ra, rb;
  logic [0:127] rt_wb;
  logic [0:6]   rt_addr_wb;
  logic         reg_write_wb;

  int check_count = 0;
  int pass_count  = 0;

  localparam logic [0:127] V5   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [0:127] VAAA = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
  localparam logic [0:127] V3   = 128'h33333333333333333333333333333333;
  localparam logic [0:127] V3B  = 128'h3B3B3B3B3B3B3B3B3B3B3B3B3B3B3B3B;
  localparam logic [0:127] V7   = 128'h77770000777700007777000077770000;

  register_table dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_format(dec_format),
    .dec_imm(dec_imm), .dec_ra_addr(dec_ra_addr), .dec_rb_addr(dec_rb_addr),
    .dec_rt_addr(dec_rt_addr), .dec_reg_write(dec_reg_write),
    .dec_stall(dec_stall),
    .op(op), .format(format), .imm(imm), .rt_addr(rt_addr),
    .reg_write(reg_write), .ra(ra), .rb(rb),
    .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb)
  );

  always #5 clk = ~clk;

  // Stimulus helpers (no checking inside).
  task automatic drive_dec(input logic v, input logic [0:10] o, input logic [2:0] f,
                           input logic [0:17] im, input logic [0:6] a, input logic [0:6] b,
                           input logic [0:6] t, input logic w);
    dec_valid = v; dec_op = o; dec_format = f; dec_imm = im;
    dec_ra_addr = a; dec_rb_addr = b; dec_rt_addr = t; dec_reg_write = w;
    if (v) $display("[%0t] dec op=%h ra=%0d rb=%0d rt=%0d wr=%0b", $time, o, a, b, t, w);
  endtask

  task automatic drive_wb(input logic w, input logic [0:6] a, input logic [0:127] d);
    reg_write_wb = w; rt_addr_wb = a; rt_wb = d;
    if (w) $display("[%0t] wb  r%0d <= %h", $time, a, d);
  endtask

  // Advance one clock; leaves time at posedge+1 for sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
    drive_wb(0, 0, '0);
    #3;
    check_count++; if (op !== 11'd0) $display("FAIL reset_op: got %h expected 0", op); else pass_count++;
    check_count++; if (reg_write !== 1'b0) $display("FAIL reset_reg_write: got %b expected 0", reg_write); else pass_count++;
    check_count++; if (ra !== 128'd0 || rb !== 128'd0) $display("FAIL reset_operands: got %h/%h expected 0", ra, rb); else pass_count++;
    check_count++; if (dec_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", dec_stall); else pass_count++;
    step(); step();
    @(negedge clk); reset = 1'b1;
    step();
    // Read r0 and r127 with no hazard: both zero.
    drive_dec(1, 11'h123, 3'd5, 18'h2ABCD, 7'd0, 7'd127, 7'd9, 0);
    #1;
    check_count++; if (dec_stall !== 1'b0) $display("FAIL idle_read_stall: got %b expected 0", dec_stall); else pass_count++;
    step();
    check_count++; if (ra !== 128'd0 || rb !== 128'd0) $display("FAIL idle_read_operands: got %h/%h expected 0", ra, rb); else pass_count++;
    check_count++; if (op !== 11'h123 || format !== 3'd5 || imm !== 18'h2ABCD || rt_addr !== 7'd9)
      $display("FAIL idle_read_fields: got %h/%0d/%h/%0d expected 123/5/2abcd/9", op, format, imm, rt_addr); else pass_count++;
    drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_writeback();
    drive_wb(1, 7'd5, V5);
    step();
    check_count++; if (op !== 11'd0 || ra !== 128'd0) $display("FAIL wb_idle_nop: got op=%h ra=%h expected 0", op, ra); else pass_count++;
    drive_wb(0, 0, '0);
    drive_dec(1, 11'h055, 3'd1, 18'd0, 7'd5, 7'd5, 7'd0, 0);
    #1;
    check_count++; if (dec_stall !== 1'b0) $display("FAIL wb_read_stall: got %b expected 0", dec_stall); else pass_count++;
    step();
    check_count++; if (ra !== V5) $display("FAIL wb_read_ra: got %h expected %h", ra, V5); else pass_count++;
    check_count++; if (rb !== V5) $display("FAIL wb_read_rb: got %h expected %h", rb, V5); else pass_count++;
    drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_raw();
    drive_dec(1, 11'h012, 3'd2, 18'd7, 7'd1, 7'd2, 7'd10, 1);
    step();
    check_count++; if (reg_write !== 1'b1 || rt_addr !== 7'd10) $display("FAIL raw_producer: got wr=%b rt=%0d expected 1/10", reg_write, rt_addr); else pass_count++;
    drive_dec(1, 11'h0A0, 3'd3, 18'd1, 7'd10, 7'd5, 7'd0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_count++; if (dec_stall !== 1'b1) $display("FAIL raw_stall_%0d: got %b expected 1", i, dec_stall); else pass_count++;
      step();
      check_count++; if (op !== 11'd0 || reg_write !== 1'b0 || ra !== 128'd0)
        $display("FAIL raw_nop_%0d: got op=%h wr=%b ra=%h expected 0", i, op, reg_write, ra); else pass_count++;
    end
    drive_wb(1, 7'd10, VAAA);
    #1;
    check_count++; if (dec_stall !== 1'b0) $display("FAIL raw_release: got %b expected 0", dec_stall); else pass_count++;
    step();
    drive_wb(0, 0, '0);
    drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
    check_count++; if (ra !== VAAA) $display("FAIL raw_forward_ra: got %h expected %h", ra, VAAA); else pass_count++;
    check_count++; if (op !== 11'h0A0 || rb !== V5) $display("FAIL raw_issue: got op=%h rb=%h expected 0a0/%h", op, rb, V5); else pass_count++;
    step();
    check_count++; if (op !== 11'd0) $display("FAIL raw_one_cycle: got op=%h expected 0", op); else pass_count++;
    // r10 now stored and no longer pending.
    drive_dec(1, 11'h0B0, 3'd0, 18'd0, 7'd0, 7'd10, 7'd0, 0);
    #1;
    check_count++; if (dec_stall !== 1'b0) $display("FAIL raw_cleared: got %b expected 0", dec_stall); else pass_count++;
    step();
    check_count++; if (rb !== VAAA) $display("FAIL raw_stored: got %h expected %h", rb, VAAA); else pass_count++;
    drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_waw();
    drive_dec(1, 11'h031, 3'd0, 18'd0, 7'd0, 7'd0, 7'd3, 1);
    step();
    drive_dec(1, 11'h032, 3'd0, 18'd0, 7'd0, 7'd0, 7'd3, 1);
    #1;
    check_count++; if (dec_stall !== 1'b1) $display("FAIL waw_stall: got %b expected 1", dec_stall); else pass_count++;
    step();
    check_count++; if (reg_write !== 1'b0 || op !== 11'd0) $display("FAIL waw_nop: got wr=%b op=%h expected 0", reg_write, op); else pass_count++;
    drive_wb(1, 7'd3, V3);
    #1;
    check_count++; if (dec_stall !== 1'b0) $display("FAIL waw_release: got %b expected 0", dec_stall); else pass_count++;
    step();
    drive_wb(0, 0, '0);
    check_count++; if (reg_write !== 1'b1 || rt_addr !== 7'd3 || op !== 11'h032)
      $display("FAIL waw_issue: got wr=%b rt=%0d op=%h expected 1/3/032", reg_write, rt_addr, op); else pass_count++;
    // Set won over the same-cycle clear: reading r3 must stall.
    drive_dec(1, 11'h033, 3'd0, 18'd0, 7'd3, 7'd0, 7'd0, 0);
    #1;
    check_count++; if (dec_stall !== 1'b1) $display("FAIL waw_set_wins: got %b expected 1", dec_stall); else pass_count++;
    step();
    drive_wb(1, 7'd3, V3B);
    #1;
    check_count++; if (dec_stall !== 1'b0) $display("FAIL waw_final_release: got %b expected 0", dec_stall); else pass_count++;
    step();
    drive_wb(0, 0, '0);
    drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
    check_count++; if (ra !== V3B) $display("FAIL waw_final_ra: got %h expected %h", ra, V3B); else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [0:10] ops [4];
    ops[0] = 11'h101; ops[1] = 11'h202; ops[2] = 11'h303; ops[3] = 11'h404;
    for (int i = 0; i < 4; i++) begin
      drive_dec(1, ops[i], 3'(i), 18'(i), 7'd5, 7'd10, 7'(20 + i), 0);
      #1;
      check_count++; if (dec_stall !== 1'b0) $display("FAIL b2b_stall_%0d: got %b expected 0", i, dec_stall); else pass_count++;
      step();
      check_count++; if (op !== ops[i] || ra !== V5 || rb !== VAAA || rt_addr !== 7'(20 + i))
        $display("FAIL b2b_issue_%0d: got op=%h rt=%0d expected %h/%0d", i, op, rt_addr, ops[i], 20 + i); else pass_count++;
    end
    drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset_midstall();
    drive_dec(1, 11'h070, 3'd0, 18'd0, 7'd0, 7'd0, 7'd7, 1);
    step();
    drive_dec(1, 11'h071, 3'd0, 18'd0, 7'd7, 7'd5, 7'd0, 0);
    #1;
    check_count++; if (dec_stall !== 1'b1) $display("FAIL rst_mid_stall: got %b expected 1", dec_stall); else pass_count++;
    #1 reset = 1'b0;
    #1;
    check_count++; if (dec_stall !== 1'b0) $display("FAIL rst_mid_stall_clear: got %b expected 0", dec_stall); else pass_count++;
    check_count++; if (reg_write !== 1'b0 || rt_addr !== 7'd0 || op !== 11'd0)
      $display("FAIL rst_mid_nop: got wr=%b rt=%0d op=%h expected 0", reg_write, rt_addr, op); else pass_count++;
    @(negedge clk); reset = 1'b1;
    #1;
    check_count++; if (dec_stall !== 1'b0) $display("FAIL rst_after_stall: got %b expected 0", dec_stall); else pass_count++;
    step();
    check_count++; if (op !== 11'h071 || ra !== 128'd0 || rb !== 128'd0)
      $display("FAIL rst_after_read: got op=%h ra=%h rb=%h expected 071/0/0", op, ra, rb); else pass_count++;
    // Late writeback after reset is written normally.
    drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
    drive_wb(1, 7'd7, V7);
    step();
    drive_wb(0, 0, '0);
    drive_dec(1, 11'h072, 3'd0, 18'd0, 7'd7, 7'd0, 7'd0, 0);
    #1;
    check_count++; if (dec_stall !== 1'b0) $display("FAIL late_wb_stall: got %b expected 0", dec_stall); else pass_count++;
    step();
    check_count++; if (ra !== V7) $display("FAIL late_wb_ra: got %h expected %h", ra, V7); else pass_count++;
    drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_raw();
    test_waw();
    test_back_to_back();
    test_reset_midstall();
    step();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/register_table.md
# register_table

Register file and issue stage for the fixed-point execution pipes. It holds the 128 × 128-bit SPU register table and reads ra/rb operands for each decoded instruction. It tracks pending destination writes in a scoreboard and stalls decode on hazards. It presents one registered instruction per cycle to the execution unit and absorbs that unit's writeback port (rt_wb, rt_addr_wb, reg_write_wb).

## Interface
Parameters:
- NUM_REGS, 128, register table depth (address width fixed at 7)
- REG_WIDTH, 128, register width in bits (big-endian bit order [0:REG_WIDTH-1])

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserting it (0) immediately clears all state
- dec_valid  in  1  decode presents an instruction this cycle
- dec_op  in  [0:10]  opcode, passed through
- dec_format  in  [2:0]  format, passed through
- dec_imm  in  [0:17]  immediate, passed through
- dec_ra_addr, dec_rb_addr  in  [0:6]  source register addresses
- dec_rt_addr  in  [0:6]  destination register address
- dec_reg_write  in  1  instruction writes rt
- dec_stall  out  1  combinational; 1 means the instruction is not accepted and decode must hold it
- op  out  [0:10]; format  out  [2:0]; imm  out  [0:17]; rt_addr  out  [0:6]; reg_write  out  1  registered issue fields to the execution unit
- ra, rb  out  [0:127]  registered operand values
- rt_wb  in  [0:127]; rt_addr_wb  in  [0:6]; reg_write_wb  in  1  writeback from the execution unit

## Operation
- Storage: the register array is regs[0..127], and all 128 entries are writable. A pending[0..127] scoreboard holds one bit per register.
- Writeback: when reg_write_wb=1, regs[rt_addr_wb] takes rt_wb at the edge and pending[rt_addr_wb] clears.
  - A writeback to a non-pending address still writes; its pending bit stays 0.
- Hazard check on ra, rb:
  - A source is "blocked" if pending[addr]=1 and it is not being cleared this cycle.
  - It is being cleared when reg_write_wb=1 and rt_addr_wb equals addr.
- Hazard check on rt:
  - When dec_reg_write=1, pending[dec_rt_addr] blocks issue under the same rule (WAW).
  - As a result, at most one write per register is ever in flight.
- dec_stall = dec_valid & (ra blocked | rb blocked | rt blocked).
- Accept: dec_valid=1 and dec_stall=0.
  - Next-cycle outputs load the dec_* fields.
  - ra/rb load the operand value. If the same-cycle writeback targets that address, the operand is forwarded from rt_wb; otherwise it is read from regs.
  - If dec_reg_write=1, pending[dec_rt_addr] sets.
- Same address set by an accept and cleared by a writeback in the same cycle: the set wins, so pending ends at 1.
- No accept (dec_valid=0 or stalled): the next cycle issues a nop.
  - op=0, format=0, rt_addr=0, reg_write=0, imm=0, ra=0, rb=0.
  - No scoreboard change from the issue side.

## Timing
- Reset values (asserted asynchronously, held while reset=0):
  - regs all 0
  - pending all 0
  - all issue outputs 0, i.e. a nop
  - dec_stall is then a function of inputs only and is 0, because no register is pending.
- Issue latency: an instruction accepted at edge N appears on the issue outputs during cycle N..N+1, for exactly one cycle.
- Writeback latency: a value on rt_wb is architecturally visible in regs after the capturing edge. A same-cycle read gets it through forwarding, so the effective read-after-writeback latency is 0 cycles.
- Stall release: dec_stall deasserts in the same cycle that reg_write_wb=1 presents the blocking address. The instruction issues at that edge with the forwarded operand.
- Reset asserted mid-stall or with writes in flight:
  - All pending bits clear, and late writebacks arriving after reset are written normally.
  - Issue outputs drop to nop asynchronously.
- Back-to-back issue with no hazards: one instruction per cycle, dec_stall stays 0.

## Test plan
- Reset then idle → all outputs 0, dec_stall=0. A read of any register (e.g. r0, r127) with no hazard issues ra=rb=0.
- Writeback reg_write_wb=1, rt_addr_wb=5, rt_wb=128'h0123…EF; next cycle issue ra=5, rb=5 → ra=rb=128'h0123…EF, dec_stall=0.
- RAW: issue rt=10 with reg_write=1, then issue ra=10.
  - dec_stall=1 every cycle until reg_write_wb=1, rt_addr_wb=10, rt_wb=128'hAAAA…
  - In that cycle dec_stall=0, and the next cycle ra=128'hAAAA… (forwarded).
- WAW: issue rt=3 writes twice in a row → the second is stalled until writeback to r3, then issues. pending[3]=1 after that edge (set wins).
- Stall with dec_valid held → the issue outputs show nop (op=0, reg_write=0) each stalled cycle and the decode fields stay unconsumed.
- Reset asserted while r7 is pending and decode stalled on r7 → dec_stall=0 immediately and outputs become nop. After release, issue reading r7 proceeds without stall and returns 0.
